axis_lfsr_checker: RTL and testbench

//  AXI4-Stream slave that consumes the 64-bit XNOR-LFSR test pattern produced by the pattern source and

---
 rtl/axis_lfsr_pkg.sv | 29 ++
 rtl/popcount64.sv | 37 +++
 rtl/axis_lfsr_checker.sv | 188 ++++++++++++++++++
 tb/tb_axis_lfsr_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_lfsr_pkg.sv
// Shared definitions for the 64-bit XNOR-LFSR pattern source and checker.
// Holds the step function, seed/lockup constants, FSM states and stats payload.
package axis_lfsr_pkg;

    localparam int unsigned LFSR_W = 64;
    localparam int unsigned TAP_HI = 62;
    localparam int unsigned TAP_LO = 61;
    localparam int unsigned POP_W  = 7;

    localparam logic [LFSR_W-1:0] LFSR_SEED   = 64'h5555_5555_5555_5555;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    // Stage-1 stats payload: accepted-while-locked flag and error vector
    typedef struct packed {
        logic              beat;
        logic [LFSR_W-1:0] diff;
    } stat_stage_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ~^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/popcount64.sv
// Combinational 64-bit population count built as a balanced adder tree.
module popcount64
    import axis_lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] data,
    output logic [POP_W-1:0]  count_c
);

    logic [1:0] lvl1 [32];
    logic [2:0] lvl2 [16];
    logic [3:0] lvl3 [8];
    logic [4:0] lvl4 [4];
    logic [5:0] lvl5 [2];

    for (genvar i = 0; i < 32; i++) begin : g_lvl1
        assign lvl1[i] = 2'(data[2*i]) + 2'(data[2*i+1]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_lvl2
        assign lvl2[i] = 3'(lvl1[2*i]) + 3'(lvl1[2*i+1]);
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl3
        assign lvl3[i] = 4'(lvl2[2*i]) + 4'(lvl2[2*i+1]);
    end

    for (genvar i = 0; i < 4; i++) begin : g_lvl4
        assign lvl4[i] = 5'(lvl3[2*i]) + 5'(lvl3[2*i+1]);
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl5
        assign lvl5[i] = 6'(lvl4[2*i]) + 6'(lvl4[2*i+1]);
    end

    assign count_c = POP_W'(lvl5[0]) + POP_W'(lvl5[1]);

endmodule

// File: rtl/axis_lfsr_checker.sv
// AXI4-Stream sink that self-synchronises to the XNOR-LFSR pattern and
// accumulates word/bit error and beat statistics while locked.
module axis_lfsr_checker
    import axis_lfsr_pkg::*;
#(
    parameter int unsigned LFSR_WIDTH       = 64,
    parameter int unsigned AXIS_TDATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH        = 32,
    parameter int unsigned LOCK_COUNT       = 4,
    parameter int unsigned UNLOCK_COUNT     = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        clr,
    output logic                        locked,
    output logic                        lost_lock,
    output logic [CNT_WIDTH-1:0]        err_words,
    output logic [CNT_WIDTH-1:0]        err_bits,
    output logic [CNT_WIDTH-1:0]        beats
);

    if (LFSR_WIDTH != LFSR_W) begin : g_bad_lfsr_width
        $fatal(1, "axis_lfsr_checker: LFSR_WIDTH must be 64");
    end
    if (AXIS_TDATA_WIDTH != LFSR_WIDTH) begin : g_bad_tdata_width
        $fatal(1, "axis_lfsr_checker: AXIS_TDATA_WIDTH must equal LFSR_WIDTH");
    end
    if (LOCK_COUNT < 1 || UNLOCK_COUNT < 1) begin : g_bad_counts
        $fatal(1, "axis_lfsr_checker: LOCK_COUNT and UNLOCK_COUNT must be >= 1");
    end

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W   = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned SUM_W   = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    lfsr_state_e         state_q, state_d;
    logic [LFSR_W-1:0]   pred_q, pred_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic                locked_d, lost_lock_d;

    logic                beat;
    logic                rx_match;
    logic                rx_lockup;

    stat_stage_t         s1_q, s1_d;
    logic [POP_W-1:0]    s1_pop;
    logic [SUM_W-1:0]    bits_sum;
    logic [CNT_WIDTH-1:0] bits_sat;

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign rx_match  = (s_axis_tdata == pred_q);
    assign rx_lockup = (s_axis_tdata == LFSR_LOCKUP);

    // Ready is held low for the first cycle out of reset, then stays high
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= HUNT;
            pred_q    <= LFSR_SEED;
            match_q   <= '0;
            bad_q     <= '0;
            locked    <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            bad_q     <= bad_d;
            locked    <= locked_d;
            lost_lock <= lost_lock_d;
        end
    end

    // Once locked the predictor free-runs so a corrupt word cannot reseed it
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_d     = match_q;
        bad_d       = bad_q;
        locked_d    = 1'b0;
        lost_lock_d = 1'b0;

        case (state_q)
            HUNT: begin
                if (beat && !rx_lockup) begin
                    pred_d  = lfsr_next(s_axis_tdata);
                    match_d = '0;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (beat) begin
                    if (rx_match) begin
                        match_d = match_q + MATCH_W'(1);
                        pred_d  = lfsr_next(s_axis_tdata);
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else if (rx_lockup) begin
                        state_d = HUNT;
                    end else begin
                        pred_d  = lfsr_next(s_axis_tdata);
                        match_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (beat) begin
                    pred_d = lfsr_next(pred_q);
                    if (rx_match) begin
                        bad_d = '0;
                    end else if (bad_q == BAD_W'(UNLOCK_COUNT - 1)) begin
                        bad_d   = '0;
                        state_d = HUNT;
                    end else begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (state_d == LOCKED) begin
            locked_d = 1'b1;
        end
        if (state_q == LOCKED && state_d == HUNT) begin
            lost_lock_d = 1'b1;
        end
    end

    assign s1_d.beat = beat && (state_q == LOCKED);
    assign s1_d.diff = s_axis_tdata ^ pred_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    popcount64 u_popcount (
        .data    (s1_q.diff),
        .count_c (s1_pop)
    );

    // Widened add so even a +64 step clamps instead of wrapping
    always_comb begin
        bits_sum = SUM_W'(err_bits) + SUM_W'(s1_pop);
        bits_sat = (bits_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(bits_sum);
    end

    // clr takes priority over a coincident stage-2 update
    always_ff @(posedge aclk) begin
        if (!aresetn || clr) begin
            err_words <= '0;
            err_bits  <= '0;
            beats     <= '0;
        end else if (s1_q.beat) begin
            if (beats != CNT_MAX) begin
                beats <= beats + CNT_WIDTH'(1);
            end
            if (s1_q.diff != '0) begin
                if (err_words != CNT_MAX) begin
                    err_words <= err_words + CNT_WIDTH'(1);
                end
                err_bits <= bits_sat;
            end
        end
    end

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Directed bench for axis_lfsr_checker: lock acquisition, error counting,
// unlock/relock, lockup rejection, tvalid gaps, saturation, clr and reset.
module tb_axis_lfsr_checker;

    localparam logic [63:0] SEED   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] LOCKUP = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        clr;
    logic        locked;
    logic        lost_lock;
    logic [31:0] err_words;
    logic [31:0] err_bits;
    logic [31:0] beats;

    logic        sat_tready;
    logic        sat_locked;
    logic        sat_lost_lock;
    logic [3:0]  sat_err_words;
    logic [3:0]  sat_err_bits;
    logic [3:0]  sat_beats;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [63:0] s;
    logic [63:0] w;
    logic [63:0] eb_exp;

    always #5 aclk = ~aclk;

    axis_lfsr_checker u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .clr           (clr),
        .locked        (locked),
        .lost_lock     (lost_lock),
        .err_words     (err_words),
        .err_bits      (err_bits),
        .beats         (beats)
    );

    axis_lfsr_checker #(.CNT_WIDTH(4)) u_sat (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tready (sat_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .clr           (clr),
        .locked        (sat_locked),
        .lost_lock     (sat_lost_lock),
        .err_words     (sat_err_words),
        .err_bits      (sat_err_bits),
        .beats         (sat_beats)
    );

    always @(posedge aclk) begin
        if (lost_lock) pulses++;
    end

    function automatic logic [63:0] tb_next(input logic [63:0] v);
        return {v[62:0], ~(v[62] ^ v[61])};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One beat: hold tvalid until an edge where tready was high
    task automatic send(input logic [63:0] d);
        logic rdy;
        logic done;
        done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        for (int k = 0; k < 8 && !done; k++) begin
            rdy = s_axis_tready;
            @(posedge aclk);
            #1;
            if (rdy) done = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        check("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        clr           = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_locked",    64'(locked),        64'd0);
        check("rst_lost_lock", 64'(lost_lock),     64'd0);
        check("rst_err_words", 64'(err_words),     64'd0);
        check("rst_err_bits",  64'(err_bits),      64'd0);
        check("rst_beats",     64'(beats),         64'd0);
        check("rst_tready",    64'(s_axis_tready), 64'd0);
        aresetn = 1'b1;
        check("tready_first_cycle", 64'(s_axis_tready), 64'd0);
        idle(1);
        check("tready_after", 64'(s_axis_tready), 64'd1);

        // Acquire lock on the seeded sequence
        s = SEED;
        for (int i = 1; i <= 20; i++) begin
            send(s);
            s = tb_next(s);
            if (i == 4) check("t1_unlocked_beat4", 64'(locked), 64'd0);
            if (i == 5) check("t1_locked_beat5",   64'(locked), 64'd1);
        end
        idle(2);
        check("t1_err_words", 64'(err_words), 64'd0);
        check("t1_err_bits",  64'(err_bits),  64'd0);
        check("t1_beats",     64'(beats),     64'd15);
        check("t1_sat_beats", 64'(sat_beats), 64'd15);

        // Single-bit error
        send(s);        s = tb_next(s);
        send(s ^ 64'd1); s = tb_next(s);
        check("t2_locked_after_err", 64'(locked), 64'd1);
        repeat (3) begin send(s); s = tb_next(s); end
        idle(2);
        check("t2_err_words", 64'(err_words), 64'd1);
        check("t2_err_bits",  64'(err_bits),  64'd1);
        check("t2_beats",     64'(beats),     64'd20);
        check("t2_sat_beats", 64'(sat_beats), 64'd15);

        // Whole-word inversion, then 7 bad beats followed by a good one
        send(~s); s = tb_next(s);
        send(s);  s = tb_next(s);
        idle(2);
        check("t3_err_words",    64'(err_words),    64'd2);
        check("t3_err_bits",     64'(err_bits),     64'd65);
        check("t3_beats",        64'(beats),        64'd22);
        check("t3_sat_err_bits", 64'(sat_err_bits), 64'd15);
        repeat (7) begin send(~s); s = tb_next(s); end
        send(s); s = tb_next(s);
        idle(2);
        check("t3_locked_7bad",  64'(locked),    64'd1);
        check("t3_no_pulse",     64'(pulses),    64'd0);
        check("t3_err_words_7",  64'(err_words), 64'd9);
        check("t3_err_bits_7",   64'(err_bits),  64'd513);
        check("t3_beats_7",      64'(beats),     64'd30);

        // Eight random words drop lock
        eb_exp = 64'd513;
        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            if (w == s) w = ~w;
            eb_exp = eb_exp + 64'($countones(w ^ s));
            send(w);
            s = tb_next(s);
            if (i == 6) check("t4_locked_7rand", 64'(locked), 64'd1);
        end
        check("t4_lost_lock_pulse", 64'(lost_lock), 64'd1);
        check("t4_locked_dropped",  64'(locked),    64'd0);
        idle(1);
        check("t4_lost_lock_end", 64'(lost_lock), 64'd0);
        check("t4_pulse_count",   64'(pulses),    64'd1);
        idle(1);
        check("t4_err_words",      64'(err_words),     64'd17);
        check("t4_err_bits",       64'(err_bits),      eb_exp);
        check("t4_beats",          64'(beats),         64'd38);
        check("t4_sat_err_words",  64'(sat_err_words), 64'd15);
        check("t4_sat_err_bits",   64'(sat_err_bits),  64'd15);

        // Relock from an arbitrary state
        s = 64'h0123_4567_89AB_CDEF;
        for (int i = 1; i <= 5; i++) begin
            send(s);
            s = tb_next(s);
            if (i == 4) check("t4_relock_beat4", 64'(locked), 64'd0);
            if (i == 5) check("t4_relock_beat5", 64'(locked), 64'd1);
        end
        idle(2);
        check("t4_beats_hold", 64'(beats), 64'd38);

        // Reset mid-stream while locked
        send(s); s = tb_next(s);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = s;
        aresetn       = 1'b0;
        idle(2);
        check("t6_rst_locked",    64'(locked),    64'd0);
        check("t6_rst_lost_lock", 64'(lost_lock), 64'd0);
        check("t6_rst_err_words", 64'(err_words), 64'd0);
        check("t6_rst_err_bits",  64'(err_bits),  64'd0);
        check("t6_rst_beats",     64'(beats),     64'd0);
        check("t6_rst_no_pulse",  64'(pulses),    64'd1);
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b1;

        // Lockup words in HUNT must never seed the predictor
        repeat (5) send(LOCKUP);
        idle(1);
        check("t5_lockup_hunt", 64'(locked), 64'd0);

        // Seeded run again with random tvalid gaps
        s = SEED;
        for (int i = 1; i <= 20; i++) begin
            send(s);
            s = tb_next(s);
            if (i == 4) check("t5_gap_unlocked_beat4", 64'(locked), 64'd0);
            if (i == 5) check("t5_gap_locked_beat5",   64'(locked), 64'd1);
            idle(int'($urandom_range(0, 1)));
        end
        idle(2);
        check("t5_gap_err_words", 64'(err_words), 64'd0);
        check("t5_gap_err_bits",  64'(err_bits),  64'd0);
        check("t5_gap_beats",     64'(beats),     64'd15);

        // clr coincident with an error beat's counter update
        send(s ^ 64'hFF); s = tb_next(s);
        clr = 1'b1;
        @(posedge aclk);
        #1;
        clr = 1'b0;
        check("t6_clr_err_words", 64'(err_words), 64'd0);
        check("t6_clr_err_bits",  64'(err_bits),  64'd0);
        check("t6_clr_beats",     64'(beats),     64'd0);
        idle(1);
        check("t6_clr_dropped",   64'(err_words), 64'd0);
        check("t6_clr_locked",    64'(locked),    64'd1);
        send(s); s = tb_next(s);
        idle(2);
        check("t6_post_clr_beats",     64'(beats),     64'd1);
        check("t6_post_clr_err_words", 64'(err_words), 64'd0);
        check("t6_post_clr_locked",    64'(locked),    64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
